// File: rtl/palm_locator.sv
// palm_locator: scans a segmented frame and reports the first horizontal hand run at least MIN_WIDTH wide.
// Optional macro PALM_TEST_OVERRIDE_EN adds a manual palm-height override (testing_switch, palm_height_test).
`default_nettype none

module palm_locator #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int COORD_W    = 8,
  parameter int MIN_WIDTH  = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic               pix_data,
  input  logic               sof,
`ifdef PALM_TEST_OVERRIDE_EN
  input  logic               testing_switch,
  input  logic [COORD_W-1:0] palm_height_test,
`endif
  output logic [COORD_W-1:0] start_r,
  output logic [COORD_W-1:0] start_c,
  output logic [COORD_W-1:0] end_r,
  output logic [COORD_W-1:0] end_c,
  output logic [COORD_W-1:0] palm_width,
  output logic [COORD_W-1:0] palm_height,
  output logic               palm_valid,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] MIN_W    = COORD_W'(MIN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FOUND = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] row, col, cur_r, cur_c;
  logic               in_run;
  logic [COORD_W-1:0] run_r, run_c;

  logic               take, scan_px, last_col, last_pix, run_active, run_end, accept;
  logic [COORD_W-1:0] seg_r, seg_c, seg_end_c, seg_w, h_sat, h_sel;
  logic [COORD_W:0]   h_full;

  always_comb begin
    take       = pix_valid && (sof || state != IDLE);
    scan_px    = pix_valid && (sof || state == SCAN);
    // sof overrides the counters so the marked pixel is always (0,0)
    cur_r      = sof ? '0 : row;
    cur_c      = sof ? '0 : col;
    last_col   = (cur_c == LAST_COL);
    last_pix   = take && last_col && (cur_r == LAST_ROW);
    run_active = in_run && !sof;
    seg_r      = run_active ? run_r : cur_r;
    seg_c      = run_active ? run_c : cur_c;
    run_end    = 1'b0;
    seg_end_c  = cur_c;
    if (scan_px) begin
      if (pix_data && last_col) begin
        run_end   = 1'b1;
        seg_end_c = cur_c;
      end else if (!pix_data && run_active) begin
        run_end   = 1'b1;
        seg_end_c = cur_c - COORD_W'(1);
      end
    end
    seg_w  = seg_end_c - seg_c + COORD_W'(1);
    accept = run_end && (seg_w >= MIN_W);
    h_full = {1'b0, seg_w} + {2'b00, seg_w[COORD_W-1:1]};
    h_sat  = h_full[COORD_W] ? '1 : h_full[COORD_W-1:0];
`ifdef PALM_TEST_OVERRIDE_EN
    h_sel  = testing_switch ? palm_height_test : h_sat;
`else
    h_sel  = h_sat;
`endif
  end

  always_comb begin
    state_nxt = state;
    if (pix_valid && sof) state_nxt = SCAN;
    if (accept)           state_nxt = FOUND;
    if (last_pix)         state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (take) begin
      if (last_col) begin
        col <= '0;
        row <= (cur_r == LAST_ROW) ? '0 : cur_r + COORD_W'(1);
      end else begin
        col <= cur_c + COORD_W'(1);
        row <= cur_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_run <= 1'b0;
      run_r  <= '0;
      run_c  <= '0;
    end else if (scan_px) begin
      if (run_end) begin
        in_run <= 1'b0;
      end else if (pix_data && !run_active) begin
        in_run <= 1'b1;
        run_r  <= cur_r;
        run_c  <= cur_c;
      end else if (sof) begin
        in_run <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r     <= '0;
      start_c     <= '0;
      end_r       <= '0;
      end_c       <= '0;
      palm_width  <= '0;
      palm_height <= '0;
      palm_valid  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= last_pix;
      if (accept) begin
        start_r     <= seg_r;
        start_c     <= seg_c;
        end_r       <= cur_r;
        end_c       <= seg_end_c;
        palm_width  <= seg_w;
        palm_height <= h_sel;
        palm_valid  <= 1'b1;
      end else if (pix_valid && sof) begin
        palm_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_palm_locator.sv
// tb_palm_locator: table-driven frames with a scoreboard of expected palm results and frame_done pulses.
`default_nettype none

module tb_palm_locator;

  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_valid, pix_data, sof;
  logic [7:0] start_r, start_c, end_r, end_c, palm_width, palm_height;
  logic       palm_valid, frame_done, busy;
`ifdef PALM_TEST_OVERRIDE_EN
  logic       testing_switch;
  logic [7:0] palm_height_test;
`endif

  palm_locator dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data), .sof(sof),
`ifdef PALM_TEST_OVERRIDE_EN
    .testing_switch(testing_switch), .palm_height_test(palm_height_test),
`endif
    .start_r(start_r), .start_c(start_c), .end_r(end_r), .end_c(end_c),
    .palm_width(palm_width), .palm_height(palm_height),
    .palm_valid(palm_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r1, c1, n1, r2, c2, n2;
    int gaps;
    int tr, tc;
    int sr, sc, er, ec, w, h;
  } vec_t;

  typedef struct {
    int cyc;
    int sr, sc, er, ec, w, h;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   ncyc       = 0;
  logic pv_prev    = 1'b0;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic s);
    @(negedge clk);
    pix_valid = v;
    pix_data  = d;
    sof       = s;
    ncyc++;
  endtask

  function automatic bit hand(input vec_t v, input int r, input int c);
    return (v.n1 > 0 && r == v.r1 && c >= v.c1 && c < v.c1 + v.n1) ||
           (v.n2 > 0 && r == v.r2 && c >= v.c2 && c < v.c2 + v.n2);
  endfunction

  task automatic run_frame(input vec_t v);
    int   last;
    exp_t e;
    last = (v.r2 > v.r1) ? v.r2 : v.r1;
    for (int r = 0; r <= last; r++) begin
      for (int c = 0; c < W; c++) begin
        if (v.gaps != 0)
          repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b1, hand(v, r, c), (r == 0 && c == 0));
        if (r == v.tr && c == v.tc) begin
          e = '{ncyc, v.sr, v.sc, v.er, v.ec, v.w, v.h};
          exp_q.push_back(e);
        end
        if (r == 0 && c == 0) begin
          @(posedge clk);
          #1;
          check("sof_clears_valid", int'(palm_valid), 0);
        end
      end
    end
  endtask

  // Full 160x120 frame with an optional run on the final row
  task automatic full_frame(input int run_c0, input int run_n, input bit expect_acc);
    exp_t e;
    for (int i = 0; i < W * H; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      step(1'b1, (r == H - 1 && c >= run_c0 && c < run_c0 + run_n), (i == 0));
      if (i == W * H - 1) begin
        fd_q.push_back(ncyc);
        if (expect_acc) begin
          e = '{ncyc, H - 1, run_c0, H - 1, run_c0 + run_n - 1, run_n, run_n + run_n / 2};
          exp_q.push_back(e);
        end
      end
      if (i == 0) begin
        @(posedge clk);
        #1;
        check("full_frame_sof_valid", int'(palm_valid), 0);
      end
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   f;
    #1;
    if (rst_n) begin
      if (palm_valid && !pv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_palm_valid", int'(palm_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("accept_cycle", ncyc, e.cyc);
          check("start_r", int'(start_r), e.sr);
          check("start_c", int'(start_c), e.sc);
          check("end_r", int'(end_r), e.er);
          check("end_c", int'(end_c), e.ec);
          check("palm_width", int'(palm_width), e.w);
          check("palm_height", int'(palm_height), e.h);
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          check("unexpected_frame_done", int'(frame_done), 0);
        end else begin
          f = fd_q.pop_front();
          check("frame_done_cycle", ncyc, f);
        end
      end
    end
    pv_prev = palm_valid;
  end

  initial begin
    vecs[0] = '{10, 40, 30, 12, 0, 50, 0, 10, 70, 10, 40, 10, 69, 30, 45};
    vecs[1] = '{5, 0, 10, 6, 100, 60, 1, 6, 159, 6, 100, 6, 159, 60, 90};
    vecs[2] = '{2, 5, 18, 0, 0, 0, 0, 2, 23, 2, 5, 2, 22, 18, 27};
    vecs[3] = '{1, 10, 17, 3, 0, 160, 1, 3, 159, 3, 0, 3, 159, 160, 240};
    vecs[4] = '{0, 0, 19, 0, 0, 0, 0, 0, 19, 0, 0, 0, 18, 19, 28};
    vecs[5] = '{3, 5, 1, 4, 139, 20, 0, 4, 159, 4, 139, 4, 158, 20, 30};

    rst_n = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 1'b0;
    sof       = 1'b0;
`ifdef PALM_TEST_OVERRIDE_EN
    testing_switch   = 1'b0;
    palm_height_test = 8'd0;
`endif
    repeat (3) @(negedge clk);
    check("rst_palm_valid", int'(palm_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_palm_width", int'(palm_width), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // All-background frame: valid drops on sof, stays low, frame_done at the end
    full_frame(0, 0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("empty_frame_valid", int'(palm_valid), 0);
    check("empty_frame_busy", int'(busy), 0);

    // Run ending on the last pixel: acceptance and frame_done together
    full_frame(142, 18, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("lastpix_valid_held", int'(palm_valid), 1);
    check("lastpix_busy", int'(busy), 0);

    // Idle pixels without sof are ignored
    repeat (30) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("idle_valid_held", int'(palm_valid), 1);
    check("idle_start_c_held", int'(start_c), 142);

    // Asynchronous reset in the middle of a run
    step(1'b1, 1'b1, 1'b1);
    repeat (9) step(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    check("midrun_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_start_r", int'(start_r), 0);
    check("async_rst_height", int'(palm_height), 0);
    check("async_rst_valid", int'(palm_valid), 0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (40) step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_valid", int'(palm_valid), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_width", int'(palm_width), 0);
    run_frame('{0, 0, 25, 0, 0, 0, 0, 0, 25, 0, 0, 0, 24, 25, 37});

`ifdef PALM_TEST_OVERRIDE_EN
    testing_switch   = 1'b1;
    palm_height_test = 8'd77;
    run_frame('{0, 30, 20, 0, 0, 0, 0, 0, 50, 0, 30, 0, 49, 20, 77});
    testing_switch   = 1'b0;
    run_frame('{0, 30, 20, 0, 0, 0, 0, 0, 50, 0, 30, 0, 49, 20, 30});
`endif

    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);
    check("fd_q_drained", fd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
